rob_param: RTL and testbench
============================

// Module: rob_param
// PURPOSE
//  Parametrised reorder buffer between dispatch, the N writeback sources (ALU, LSB, ...),
//  the register file, the branch predictor and the LSB store path.
//  Allocates entries in order, collects results out of order and retires one entry per cycle in order.
//  Retirement of stores is held until the LSB acknowledges the store.
//  A mispredicted branch at retirement triggers a one-cycle flush with a redirect PC.
// PARAMETERS
//  DEPTH     16  entry count, power of 2; id 0 is reserved as "no dependency", so ids are 1..DEPTH-1
//  ID_W      4   log2(DEPTH), width of an entry id
//  XLEN      32  data/PC width
//  WB_PORTS  2   writeback channels; port 0 additionally carries branch resolution
// PORTS
//  clk          in   1               clock
//  rst          in   1               async active-high reset
//  rdy          in   1               global enable; 0 freezes all state (outputs hold)
//  full_o       out  1               no free entry this cycle
//  alloc_v_i    in   1               dispatch allocate request (ignored if full_o or flush_o)
//  alloc_pc_i   in   XLEN            instruction PC
//  alloc_rd_i   in   5               destination register, 0 = none
//  alloc_br_i   in   1               conditional branch
//  alloc_st_i   in   1               store
//  alloc_pt_i   in   1               predicted taken
//  alloc_id_o   out  ID_W            id granted to a request this cycle (= tail)
//  wb_v_i       in   WB_PORTS        per-port result valid
//  wb_id_i      in   WB_PORTS*ID_W   per-port entry id
//  wb_data_i    in   WB_PORTS*XLEN   per-port result
//  wb_taken_i   in   1               port 0 branch taken
//  wb_tgt_i     in   XLEN            port 0 branch target
//  qj_id_i/qk_id_i in ID_W           operand lookup ids
//  qj_rdy_o/qk_rdy_o out 1           entry ready (id 0 -> 1)
//  qj_data_o/qk_data_o out XLEN      entry result (id 0 -> 0)
//  rf_we_o, rf_rd_o[5], rf_id_o[ID_W], rf_data_o[XLEN]  out   retire write to register file
//  bp_v_o, bp_taken_o, bp_hit_o, bp_tgt_o[XLEN]         out   branch outcome to predictor
//  st_go_o  out 1, st_id_o  out ID_W, st_done_i  in 1         store commit handshake
//  flush_o  out 1, flush_pc_o out XLEN                         rollback pulse and redirect PC
// BEHAVIOUR
//  - Reset: head=tail=1, count=0, all ready bits 0; every output 0 (alloc_id_o=1, qj/qk_rdy_o=1 for id 0).
//  - Pointer wrap: DEPTH-1 -> 1, never 0. full_o = (count == DEPTH-2), so one id stays unused and
//    head==tail means empty.
//  - Alloc: entry written at tail with ready=0; tail advances next cycle.
//    Simultaneous alloc and retire keeps count unchanged.
//  - Writeback: each valid port sets ready/result of its id. Port 0 also latches taken and target.
//    Two ports hitting the same id in one cycle is illegal; the lower port wins.
//  - Lookup: combinational read of the stored ready/result; reflects registered state only.
//  - Retire FSM, states RUN, ST_WAIT:
//    RUN, head valid and ready, non-store: retire in 1 cycle; rf_we_o=1 for 1 cycle if rd!=0.
//      If it is a branch, bp_v_o=1 for 1 cycle with bp_hit_o = (taken==pred).
//      On a mispredict, flush_o=1 on the following cycle with
//      flush_pc_o = taken ? target : pc+4.
//    RUN, head store and ready: st_go_o=1 for 1 cycle with st_id_o=head, go to ST_WAIT;
//      head does not advance.
//    ST_WAIT: on st_done_i (may arrive the cycle after st_go_o or later), retire the store
//      (rf_we_o=0) and return to RUN. No other retirement occurs while waiting.
//  - Flush cycle: all entries invalidated, head=tail=1, FSM->RUN, alloc and writeback ignored,
//    flush_o drops next cycle.
//    A pending ST_WAIT is abandoned; a store waiting in ST_WAIT is older than any mispredicted
//    branch, so in practice it never coincides with a flush.
//  - Async reset mid-operation: immediate return to reset state, including from ST_WAIT or during flush_o.
//  - rdy=0: no pointer, FSM, entry or output pulse changes; pulses resume when rdy returns.
// CONFIGURATION
//  ROB_WB_BYPASS_EN defined: qj/qk lookups also compare against same-cycle wb_v_i/wb_id_i
//    (lowest matching port wins) and return rdy=1 with the forwarded data.
//  Undefined: lookups see registered state only; a result written this cycle is visible next cycle.
// TESTING
//  1 Fill: 14 allocs with no writeback -> ids 1..14 granted, full_o=1 after 14th; 15th alloc ignored, tail stays 15.
//  2 Out-of-order: alloc ids 1,2 (rd=5,6); wb id2=0x22 then id1=0x11 -> rf writes x5=0x11 then x6=0x22 on consecutive cycles.
//  3 Store: id1 store ready -> st_go_o pulse with st_id_o=1; hold st_done_i low 5 cycles -> head stays 1; st_done_i -> head=2.
//  4 Mispredict: branch pc=0x100, pred=0, wb taken=1 tgt=0x200 -> bp_hit_o=0, then flush_o=1 with flush_pc_o=0x200, head=tail=1.
//  5 Wrap: 20 alloc/retire pairs -> ids go ...,15,1,2,...; id 0 never issued.
//  6 Bypass (EN): wb id3=0xAB and qj_id_i=3 in the same cycle -> qj_rdy_o=1, qj_data_o=0xAB; without EN -> qj_rdy_o=0.

Source files
------------

// File: rtl/rob_param.sv
// rob_param: reorder buffer. Allocates in order, collects writebacks out of order, and retires one entry per cycle in order.
// Define ROB_WB_BYPASS_EN to forward same-cycle writeback results to the qj/qk operand lookups.
module rob_param #(
    parameter int DEPTH    = 16,
    parameter int ID_W     = 4,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    output logic                     full_o,
    input  logic                     alloc_v_i,
    input  logic [XLEN-1:0]          alloc_pc_i,
    input  logic [4:0]               alloc_rd_i,
    input  logic                     alloc_br_i,
    input  logic                     alloc_st_i,
    input  logic                     alloc_pt_i,
    output logic [ID_W-1:0]          alloc_id_o,
    input  logic [WB_PORTS-1:0]      wb_v_i,
    input  logic [WB_PORTS*ID_W-1:0] wb_id_i,
    input  logic [WB_PORTS*XLEN-1:0] wb_data_i,
    input  logic                     wb_taken_i,
    input  logic [XLEN-1:0]          wb_tgt_i,
    input  logic [ID_W-1:0]          qj_id_i,
    input  logic [ID_W-1:0]          qk_id_i,
    output logic                     qj_rdy_o,
    output logic                     qk_rdy_o,
    output logic [XLEN-1:0]          qj_data_o,
    output logic [XLEN-1:0]          qk_data_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_rd_o,
    output logic [ID_W-1:0]          rf_id_o,
    output logic [XLEN-1:0]          rf_data_o,
    output logic                     bp_v_o,
    output logic                     bp_taken_o,
    output logic                     bp_hit_o,
    output logic [XLEN-1:0]          bp_tgt_o,
    output logic                     st_go_o,
    output logic [ID_W-1:0]          st_id_o,
    input  logic                     st_done_i,
    output logic                     flush_o,
    output logic [XLEN-1:0]          flush_pc_o
);
    typedef enum logic {RUN, ST_WAIT} state_t;
    state_t state_q, state_d;

    logic [ID_W-1:0]             head, tail, count;
    logic [DEPTH-1:0]            e_rdy, e_br, e_st, e_pt, e_tk;
    logic [DEPTH-1:0][4:0]       e_rd;
    logic [DEPTH-1:0][XLEN-1:0]  e_pc, e_data, e_tgt;
    logic [XLEN-1:0]             redir_pc;
    logic                        do_alloc, do_retire, ret_fire, st_fire, st_ret, mp_pend;
    logic [1:0][ID_W-1:0]        lk_id;
    logic [1:0]                  lk_rdy;
    logic [1:0][XLEN-1:0]        lk_data;

    // Id 0 means "no dependency", so the pointers skip it on wrap.
    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
        return (p == ID_W'(DEPTH-1)) ? ID_W'(1) : p + ID_W'(1);
    endfunction

    assign full_o     = (count == ID_W'(DEPTH-2));
    assign alloc_id_o = tail;
    // A mispredicted branch retired last cycle: hold retirement until the flush clears the wrong path.
    assign mp_pend    = bp_v_o & ~bp_hit_o;
    assign do_alloc   = alloc_v_i & ~full_o & ~flush_o;
    assign do_retire  = ret_fire | st_ret;

    always_comb begin
        state_d  = state_q;
        ret_fire = 1'b0;
        st_fire  = 1'b0;
        st_ret   = 1'b0;
        if (flush_o) begin
            state_d = RUN;
        end else if (!mp_pend) begin
            case (state_q)
                RUN: begin
                    if (count != '0 && e_rdy[head]) begin
                        if (e_st[head]) begin
                            st_fire = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            ret_fire = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (st_done_i) begin
                        st_ret  = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_q <= RUN;
        else if (rdy) state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= ID_W'(1);
            tail       <= ID_W'(1);
            count      <= '0;
            e_rdy      <= '0;
            e_br       <= '0;
            e_st       <= '0;
            e_pt       <= '0;
            e_tk       <= '0;
            e_rd       <= '0;
            e_pc       <= '0;
            e_data     <= '0;
            e_tgt      <= '0;
            redir_pc   <= '0;
            rf_we_o    <= 1'b0;
            rf_rd_o    <= '0;
            rf_id_o    <= '0;
            rf_data_o  <= '0;
            bp_v_o     <= 1'b0;
            bp_taken_o <= 1'b0;
            bp_hit_o   <= 1'b0;
            bp_tgt_o   <= '0;
            st_go_o    <= 1'b0;
            st_id_o    <= '0;
            flush_o    <= 1'b0;
            flush_pc_o <= '0;
        end else if (rdy) begin
            rf_we_o <= ret_fire && (e_rd[head] != 5'd0);
            bp_v_o  <= ret_fire && e_br[head];
            st_go_o <= st_fire;
            flush_o <= mp_pend;
            if (ret_fire) begin
                rf_rd_o   <= e_rd[head];
                rf_id_o   <= head;
                rf_data_o <= e_data[head];
            end
            if (ret_fire && e_br[head]) begin
                bp_taken_o <= e_tk[head];
                bp_hit_o   <= (e_tk[head] == e_pt[head]);
                bp_tgt_o   <= e_tgt[head];
                redir_pc   <= e_tk[head] ? e_tgt[head] : e_pc[head] + XLEN'(4);
            end
            if (st_fire) st_id_o <= head;
            if (mp_pend) flush_pc_o <= redir_pc;

            if (flush_o) begin
                head  <= ID_W'(1);
                tail  <= ID_W'(1);
                count <= '0;
                e_rdy <= '0;
            end else begin
                // Descending loop so the lowest port's write lands last and wins a collision.
                for (int p = WB_PORTS-1; p >= 0; p--) begin
                    if (wb_v_i[p]) begin
                        e_rdy[wb_id_i[p*ID_W +: ID_W]]  <= 1'b1;
                        e_data[wb_id_i[p*ID_W +: ID_W]] <= wb_data_i[p*XLEN +: XLEN];
                    end
                end
                if (wb_v_i[0]) begin
                    e_tk[wb_id_i[ID_W-1:0]]  <= wb_taken_i;
                    e_tgt[wb_id_i[ID_W-1:0]] <= wb_tgt_i;
                end
                if (do_alloc) begin
                    e_rdy[tail] <= 1'b0;
                    e_pc[tail]  <= alloc_pc_i;
                    e_rd[tail]  <= alloc_rd_i;
                    e_br[tail]  <= alloc_br_i;
                    e_st[tail]  <= alloc_st_i;
                    e_pt[tail]  <= alloc_pt_i;
                    tail        <= nxt(tail);
                end
                if (do_retire) head <= nxt(head);
                if (do_alloc && !do_retire)      count <= count + ID_W'(1);
                else if (!do_alloc && do_retire) count <= count - ID_W'(1);
            end
        end
    end

    assign lk_id = {qk_id_i, qj_id_i};

    always_comb begin
        lk_rdy  = '0;
        lk_data = '0;
        for (int l = 0; l < 2; l++) begin
            lk_rdy[l]  = (lk_id[l] == '0) ? 1'b1 : e_rdy[lk_id[l]];
            lk_data[l] = (lk_id[l] == '0) ? '0 : e_data[lk_id[l]];
`ifdef ROB_WB_BYPASS_EN
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (wb_v_i[p] && lk_id[l] != '0 && wb_id_i[p*ID_W +: ID_W] == lk_id[l]) begin
                    lk_rdy[l]  = 1'b1;
                    lk_data[l] = wb_data_i[p*XLEN +: XLEN];
                end
            end
`endif
        end
    end

    assign qj_rdy_o  = lk_rdy[0];
    assign qj_data_o = lk_data[0];
    assign qk_rdy_o  = lk_rdy[1];
    assign qk_data_o = lk_data[1];
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_rob_param;
    logic        clk = 0, rst = 1, rdy = 1;
    logic        full_o, alloc_v, alloc_br, alloc_st, alloc_pt;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_id_o;
    logic [1:0]  wb_v;
    logic [7:0]  wb_id;
    logic [63:0] wb_data;
    logic        wb_taken;
    logic [31:0] wb_tgt;
    logic [3:0]  qj_id, qk_id;
    logic        qj_rdy_o, qk_rdy_o;
    logic [31:0] qj_data_o, qk_data_o;
    logic        rf_we_o, bp_v_o, bp_taken_o, bp_hit_o, st_go_o, st_done, flush_o;
    logic [4:0]  rf_rd_o;
    logic [3:0]  rf_id_o, st_id_o;
    logic [31:0] rf_data_o, bp_tgt_o, flush_pc_o;

    int checks = 0, errors = 0;

    rob_param dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full_o(full_o),
        .alloc_v_i(alloc_v), .alloc_pc_i(alloc_pc), .alloc_rd_i(alloc_rd),
        .alloc_br_i(alloc_br), .alloc_st_i(alloc_st), .alloc_pt_i(alloc_pt), .alloc_id_o(alloc_id_o),
        .wb_v_i(wb_v), .wb_id_i(wb_id), .wb_data_i(wb_data), .wb_taken_i(wb_taken), .wb_tgt_i(wb_tgt),
        .qj_id_i(qj_id), .qk_id_i(qk_id), .qj_rdy_o(qj_rdy_o), .qk_rdy_o(qk_rdy_o),
        .qj_data_o(qj_data_o), .qk_data_o(qk_data_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_id_o(rf_id_o), .rf_data_o(rf_data_o),
        .bp_v_o(bp_v_o), .bp_taken_o(bp_taken_o), .bp_hit_o(bp_hit_o), .bp_tgt_o(bp_tgt_o),
        .st_go_o(st_go_o), .st_id_o(st_id_o), .st_done_i(st_done),
        .flush_o(flush_o), .flush_pc_o(flush_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit [3:0] id; bit [31:0] pc; bit [4:0] rd;
        bit br, st, pt, rdy_b, tk; bit [31:0] data, tgt;
    } ent_t;
    ent_t q[$];
    ent_t h, ne;
    bit [3:0]  m_tail = 1;
    bit        m_wait = 0, old_fl, n_fl, ret, go;
    int        pre_n;
    bit        e_rf_we = 0, e_bp_v = 0, e_bp_hit = 0, e_bp_tk = 0, e_st_go = 0, e_fl = 0;
    bit [4:0]  e_rf_rd;
    bit [3:0]  e_rf_id, e_st_id;
    bit [31:0] e_rf_data, e_bp_tgt, e_fl_pc, m_redir = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete(); m_tail = 1; m_wait = 0; m_redir = 0;
            e_rf_we = 0; e_bp_v = 0; e_bp_hit = 0; e_st_go = 0; e_fl = 0;
        end else if (rdy) begin
            old_fl = e_fl;
            n_fl   = e_bp_v && !e_bp_hit;
            pre_n  = q.size();
            ret = 0; go = 0;
            if (pre_n > 0) h = q[0];
            if (!old_fl && !n_fl) begin
                if (m_wait) ret = st_done;
                else if (pre_n > 0 && h.rdy_b) begin
                    if (h.st) go = 1; else ret = 1;
                end
            end
            e_rf_we = ret && !h.st && h.rd != 0;
            if (e_rf_we) begin e_rf_rd = h.rd; e_rf_id = h.id; e_rf_data = h.data; end
            e_bp_v = ret && !h.st && h.br;
            if (e_bp_v) begin e_bp_tk = h.tk; e_bp_hit = (h.tk == h.pt); e_bp_tgt = h.tgt; end
            e_st_go = go;
            if (go) e_st_id = h.id;
            e_fl = n_fl;
            if (n_fl) e_fl_pc = m_redir;
            if (e_bp_v) m_redir = h.tk ? h.tgt : h.pc + 4;
            if (go) m_wait = 1; else if (ret && m_wait) m_wait = 0;
            if (!old_fl) begin
                for (int p = 1; p >= 0; p--)
                    if (wb_v[p])
                        foreach (q[k])
                            if (q[k].id == wb_id[p*4 +: 4]) begin
                                q[k].rdy_b = 1; q[k].data = wb_data[p*32 +: 32];
                                if (p == 0) begin q[k].tk = wb_taken; q[k].tgt = wb_tgt; end
                            end
                if (ret) void'(q.pop_front());
                if (alloc_v && pre_n < 14) begin
                    ne = '{id: m_tail, pc: alloc_pc, rd: alloc_rd, br: alloc_br, st: alloc_st,
                           pt: alloc_pt, rdy_b: 0, tk: 0, data: 0, tgt: 0};
                    q.push_back(ne);
                    m_tail = (m_tail == 15) ? 4'd1 : m_tail + 4'd1;
                end
            end else begin
                q.delete(); m_tail = 1; m_wait = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit        lf, lr;
    bit [31:0] ld;
    logic [3:0] lid;
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_full", full_o, q.size() == 14);
            chk("m_alloc_id", alloc_id_o, m_tail);
            chk("m_rf_we", rf_we_o, e_rf_we);
            if (e_rf_we) begin
                chk("m_rf_rd", rf_rd_o, e_rf_rd);
                chk("m_rf_id", rf_id_o, e_rf_id);
                chk("m_rf_data", rf_data_o, e_rf_data);
            end
            chk("m_bp_v", bp_v_o, e_bp_v);
            if (e_bp_v) begin
                chk("m_bp_taken", bp_taken_o, e_bp_tk);
                chk("m_bp_hit", bp_hit_o, e_bp_hit);
                chk("m_bp_tgt", bp_tgt_o, e_bp_tgt);
            end
            chk("m_st_go", st_go_o, e_st_go);
            if (e_st_go) chk("m_st_id", st_id_o, e_st_id);
            chk("m_flush", flush_o, e_fl);
            if (e_fl) chk("m_flush_pc", flush_pc_o, e_fl_pc);
            for (int l = 0; l < 2; l++) begin
                lid = (l == 0) ? qj_id : qk_id;
                lf = 0; lr = 0; ld = 0;
                if (lid == 0) begin lf = 1; lr = 1; end
                else foreach (q[k]) if (q[k].id == lid) begin lf = 1; lr = q[k].rdy_b; ld = q[k].data; end
`ifdef ROB_WB_BYPASS_EN
                if (lf && lid != 0)
                    for (int p = 1; p >= 0; p--)
                        if (wb_v[p] && wb_id[p*4 +: 4] == lid) begin lr = 1; ld = wb_data[p*32 +: 32]; end
`endif
                if (lf) begin
                    chk("m_lk_rdy", (l == 0) ? qj_rdy_o : qk_rdy_o, lr);
                    if (lr) chk("m_lk_data", (l == 0) ? qj_data_o : qk_data_o, ld);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(); @(posedge clk); #1; endtask
    task automatic clr();
        alloc_v = 0; alloc_pc = 0; alloc_rd = 0; alloc_br = 0; alloc_st = 0; alloc_pt = 0;
        wb_v = 0; wb_id = 0; wb_data = 0; wb_taken = 0; wb_tgt = 0; st_done = 0; qj_id = 0; qk_id = 0;
    endtask
    task automatic alloc(input logic [31:0] pc, input logic [4:0] rd, input logic br, input logic st, input logic pt);
        alloc_v = 1; alloc_pc = pc; alloc_rd = rd; alloc_br = br; alloc_st = st; alloc_pt = pt;
    endtask
    task automatic wb(input int p, input logic [3:0] id, input logic [31:0] d);
        wb_v[p] = 1'b1; wb_id[p*4 +: 4] = id; wb_data[p*32 +: 32] = d;
    endtask
    task automatic do_reset(); clr(); rdy = 1; rst = 1; step(); rst = 0; endtask

    initial begin
        clr();
        step();
        // reset state
        chk("rst_full", full_o, 0);       chk("rst_alloc_id", alloc_id_o, 1);
        chk("rst_rf_we", rf_we_o, 0);     chk("rst_rf_data", rf_data_o, 0);
        chk("rst_bp_v", bp_v_o, 0);       chk("rst_bp_hit", bp_hit_o, 0);
        chk("rst_st_go", st_go_o, 0);     chk("rst_st_id", st_id_o, 0);
        chk("rst_flush", flush_o, 0);     chk("rst_flush_pc", flush_pc_o, 0);
        chk("rst_qj_rdy", qj_rdy_o, 1);   chk("rst_qj_data", qj_data_o, 0);
        chk("rst_qk_rdy", qk_rdy_o, 1);
        rst = 0;

        // 1: fill to full, 15th alloc ignored
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            alloc(32'h40 + 4*i, 5'd1, 0, 0, 0);
            chk("t1_id", alloc_id_o, i);
            step();
        end
        chk("t1_full", full_o, 1);
        chk("t1_id15", alloc_id_o, 15);
        step();
        clr();
        chk("t1_tail_hold", alloc_id_o, 15);
        chk("t1_full_hold", full_o, 1);

        // 2: out-of-order writeback, in-order retire, rdy freeze
        do_reset();
        alloc(32'h0, 5'd5, 0, 0, 0); step();
        alloc(32'h4, 5'd6, 0, 0, 0); step();
        clr(); wb(0, 4'd2, 32'h22); step();
        clr(); wb(1, 4'd1, 32'h11); step();
        clr(); step();
        chk("t2_we1", rf_we_o, 1); chk("t2_rd1", rf_rd_o, 5); chk("t2_d1", rf_data_o, 32'h11);
        rdy = 0; step(); step();
        chk("t2_freeze_we", rf_we_o, 1); chk("t2_freeze_rd", rf_rd_o, 5);
        rdy = 1; step();
        chk("t2_we2", rf_we_o, 1); chk("t2_rd2", rf_rd_o, 6); chk("t2_d2", rf_data_o, 32'h22);
        step();
        chk("t2_we_off", rf_we_o, 0);

        // 3: store handshake
        do_reset();
        alloc(32'h10, 5'd0, 0, 1, 0); step();
        alloc(32'h14, 5'd7, 0, 0, 0); step();
        clr(); wb(0, 4'd1, 32'h0); wb(1, 4'd2, 32'h77); step();
        clr(); step();
        chk("t3_go", st_go_o, 1); chk("t3_st_id", st_id_o, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_wait_go", st_go_o, 0); chk("t3_wait_we", rf_we_o, 0);
        end
        st_done = 1; step(); st_done = 0;
        chk("t3_store_no_we", rf_we_o, 0);
        step();
        chk("t3_next_we", rf_we_o, 1); chk("t3_next_id", rf_id_o, 2); chk("t3_next_rd", rf_rd_o, 7);

        // 4: mispredict and flush
        do_reset();
        alloc(32'h100, 5'd0, 1, 0, 0); step();
        alloc(32'h104, 5'd3, 0, 0, 0); step();
        clr(); wb(0, 4'd1, 32'h0); wb_taken = 1; wb_tgt = 32'h200; wb(1, 4'd2, 32'h5); step();
        clr(); step();
        chk("t4_bp_v", bp_v_o, 1); chk("t4_bp_hit", bp_hit_o, 0); chk("t4_bp_taken", bp_taken_o, 1);
        chk("t4_bp_tgt", bp_tgt_o, 32'h200); chk("t4_no_flush_yet", flush_o, 0);
        step();
        chk("t4_flush", flush_o, 1); chk("t4_flush_pc", flush_pc_o, 32'h200); chk("t4_no_wrong_we", rf_we_o, 0);
        alloc(32'h300, 5'd4, 0, 0, 0); step(); clr();
        chk("t4_flush_drop", flush_o, 0); chk("t4_tail1", alloc_id_o, 1); chk("t4_empty", full_o, 0);

        // 5: wrap with alloc/retire pairs, some correctly predicted branches
        do_reset();
        for (int i = 0; i < 20; i++) begin
            clr();
            alloc(32'h1000 + 4*i, 5'((i % 31) + 1), (i % 4) == 0, 0, 0);
            chk("t5_id", alloc_id_o, (i % 15) + 1);
            if (i > 0) wb(0, 4'(((i - 1) % 15) + 1), 32'(i));
            step();
        end
        clr(); wb(0, 4'd5, 32'd20); step();
        clr(); step(); step(); step();

        // 6: same-cycle lookup
        do_reset();
        for (int i = 1; i <= 3; i++) begin alloc(32'h2000 + 4*i, 5'(i), 0, 0, 0); step(); end
        clr(); wb(1, 4'd3, 32'hAB); qj_id = 3; qk_id = 0; #1;
`ifdef ROB_WB_BYPASS_EN
        chk("t6_byp_rdy", qj_rdy_o, 1); chk("t6_byp_data", qj_data_o, 32'hAB);
`else
        chk("t6_nobyp_rdy", qj_rdy_o, 0);
`endif
        chk("t6_qk_rdy", qk_rdy_o, 1); chk("t6_qk_data", qk_data_o, 0);
        step(); wb_v = 0;
        chk("t6_reg_rdy", qj_rdy_o, 1); chk("t6_reg_data", qj_data_o, 32'hAB);

        // 7: async reset while waiting on a store
        do_reset();
        alloc(32'h30, 5'd0, 0, 1, 0); step();
        clr(); wb(0, 4'd1, 32'h0); step();
        clr(); step();
        chk("t7_go", st_go_o, 1);
        step(); #2; rst = 1; #1;
        chk("t7_rst_go", st_go_o, 0); chk("t7_rst_id", alloc_id_o, 1); chk("t7_rst_full", full_o, 0);
        step(); rst = 0;
        alloc(32'h34, 5'd9, 0, 0, 0); step();
        clr(); wb(0, 4'd1, 32'h99); step();
        clr(); step();
        chk("t7_run_we", rf_we_o, 1); chk("t7_run_data", rf_data_o, 32'h99);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
